// File: rtl/regfile_pkg.sv
// Shared parameters and helpers for the multi-read-port register file.
// Covers both builds: with and without REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int unsigned DefDataW = 16;
  localparam int unsigned DefAddrW = 3;
  localparam int unsigned DefNumRd = 2;

  // Next pending count from one accepted issue and one cleared set bit.
  // This avoids recounting the pending vector every cycle.
  function automatic int unsigned cnt_next(int unsigned cnt, logic inc, logic dec);
    return cnt + {31'b0, inc} - {31'b0, dec};
  endfunction

  // Register i comes out of reset holding the value i.
  function automatic int unsigned init_val(int unsigned i);
    return i;
  endfunction

endpackage

// File: rtl/regfile_if.sv
// Bus between decode/write-back and the register file: read ports,
// write-back port and load-issue port.
interface regfile_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned NUM_RD = 2
) ();

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     ld_issue;
  logic [ADDR_W-1:0]        ld_addr;
  logic                     ld_stall;
  logic [ADDR_W:0]          pend_cnt;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, ld_issue, ld_addr,
    input  rd_data, rd_busy, ld_stall, pend_cnt
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, ld_issue, ld_addr,
    output rd_data, rd_busy, ld_stall, pend_cnt
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-load scoreboard: one bit per register. A load issue sets the bit,
// and a write-back clears it. Also produces ld_stall and a running pend_cnt.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en_i,
  input  logic [ADDR_W-1:0]      wr_addr_i,
  input  logic                   ld_issue_i,
  input  logic [ADDR_W-1:0]      ld_addr_i,
  output logic [2**ADDR_W-1:0]   pending_o,
  output logic                   ld_stall_o,
  output logic [ADDR_W:0]        pend_cnt_o
);

  localparam int unsigned Depth = 2**ADDR_W;
  localparam int unsigned CntW  = ADDR_W + 1;

  logic [Depth-1:0] pending_q, pending_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             set_ok, clr_ok;

  always_comb begin
    ld_stall_o = ld_issue_i && pending_q[ld_addr_i];
    set_ok     = ld_issue_i && !pending_q[ld_addr_i];
    // A same-address issue keeps the bit set, so the write does not count as a clear.
    clr_ok     = wr_en_i && pending_q[wr_addr_i] && !(ld_issue_i && (ld_addr_i == wr_addr_i));

    pending_d = pending_q;
    if (clr_ok) pending_d[wr_addr_i] = 1'b0;
    if (set_ok) pending_d[ld_addr_i] = 1'b1;

    cnt_d = CntW'(cnt_next(32'(cnt_q), set_ok, clr_ok));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pending_o  = pending_q;
  assign pend_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with a pending-load scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned NUM_RD = DefNumRd
) (
  input  logic     clk,
  input  logic     rst_n,
  regfile_if.slave bus
);

  localparam int unsigned Depth = 2**ADDR_W;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [Depth-1:0]  pending;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= DATA_W'(init_val(i));
      end
    end else if (bus.wr_en) begin
      mem_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (bus.wr_en),
    .wr_addr_i  (bus.wr_addr),
    .ld_issue_i (bus.ld_issue),
    .ld_addr_i  (bus.ld_addr),
    .pending_o  (pending),
    .ld_stall_o (bus.ld_stall),
    .pend_cnt_o (bus.pend_cnt)
  );

  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      bus.rd_data[p*DATA_W +: DATA_W] = mem_q[bus.rd_addr[p*ADDR_W +: ADDR_W]];
      bus.rd_busy[p]                  = pending[bus.rd_addr[p*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
      if (bus.wr_en && (bus.wr_addr == bus.rd_addr[p*ADDR_W +: ADDR_W])) begin
        bus.rd_data[p*DATA_W +: DATA_W] = bus.wr_data;
        // A same-cycle load to this register keeps showing the old pending bit.
        if (!(bus.ld_issue && (bus.ld_addr == bus.rd_addr[p*ADDR_W +: ADDR_W]))) begin
          bus.rd_busy[p] = 1'b0;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed table-driven bench for regfile_mp (8x16, two read ports), plus a
// hand-written fill/drain of every pending bit.
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  typedef struct {
    logic [2:0]  a0, a1;
    logic        rst;
    logic        we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic        li;
    logic [2:0]  la;
    logic [15:0] ed0, ed1;
    logic [1:0]  eb;
    logic        es;
    logic [3:0]  ec;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  regfile_if #(.DATA_W(16), .ADDR_W(3), .NUM_RD(2)) bus ();

  regfile_mp #(
    .DATA_W (16),
    .ADDR_W (3),
    .NUM_RD (2)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(int a0, int a1, bit rst, bit we, int wa, int wd, bit li, int la,
                              int ed0, int ed1, int eb, bit es, int ec);
    vec_t v;
    v.a0 = 3'(a0);  v.a1 = 3'(a1);  v.rst = rst;  v.we = we;  v.wa = 3'(wa);
    v.wd = 16'(wd); v.li = li;      v.la = 3'(la);
    v.ed0 = 16'(ed0); v.ed1 = 16'(ed1); v.eb = 2'(eb); v.es = es; v.ec = 4'(ec);
    return v;
  endfunction

  task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.rd_addr  = '0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.ld_issue = 1'b0;
    bus.ld_addr  = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();

    // a0 a1 rst we wa wd li la | ed0 ed1 eb es ec
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(2, 3, 1, 0, 0, 0, 0, 0, 2, 3, 0, 0, 0));
    vecs.push_back(mk(4, 5, 1, 0, 0, 0, 0, 0, 4, 5, 0, 0, 0));
    vecs.push_back(mk(6, 7, 1, 0, 0, 0, 0, 0, 6, 7, 0, 0, 0));
    vecs.push_back(mk(3, 3, 1, 0, 0, 0, 1, 3, 3, 3, 0, 0, 0));
    vecs.push_back(mk(3, 0, 1, 0, 0, 0, 0, 0, 3, 0, 1, 0, 1));
    vecs.push_back(mk(3, 3, 1, 1, 3, 75, 0, 0, Byp ? 75 : 3, Byp ? 75 : 3, Byp ? 0 : 3, 0, 1));
    vecs.push_back(mk(3, 3, 1, 0, 0, 0, 0, 0, 75, 75, 0, 0, 0));
    vecs.push_back(mk(4, 3, 1, 0, 0, 0, 1, 4, 4, 75, 0, 0, 0));
    vecs.push_back(mk(4, 0, 1, 0, 0, 0, 1, 4, 4, 0, 1, 1, 1));
    vecs.push_back(mk(4, 4, 1, 1, 4, 175, 1, 4, Byp ? 175 : 4, Byp ? 175 : 4, 3, 1, 1));
    vecs.push_back(mk(4, 4, 1, 0, 0, 0, 0, 0, 175, 175, 3, 0, 1));
    vecs.push_back(mk(0, 2, 1, 1, 2, 'hAF, 0, 0, 0, Byp ? 'hAF : 2, 0, 0, 1));
    vecs.push_back(mk(0, 2, 1, 0, 0, 0, 0, 0, 0, 'hAF, 0, 0, 1));
    vecs.push_back(mk(4, 5, 1, 1, 4, 9, 1, 5, Byp ? 9 : 175, 5, Byp ? 0 : 1, 0, 1));
    vecs.push_back(mk(4, 5, 1, 0, 0, 0, 0, 0, 9, 5, 2, 0, 1));
    vecs.push_back(mk(1, 6, 1, 0, 0, 0, 1, 1, 1, 6, 0, 0, 1));
    vecs.push_back(mk(5, 1, 1, 0, 0, 0, 1, 6, 5, 1, 3, 0, 2));
    vecs.push_back(mk(6, 7, 1, 1, 7, 'h1234, 0, 0, 6, Byp ? 'h1234 : 7, 1, 0, 3));
    vecs.push_back(mk(7, 1, 1, 0, 0, 0, 0, 0, 'h1234, 1, 2, 0, 3));
    // Reset with a write and an issue in the same cycle: both must be lost.
    vecs.push_back(mk(5, 6, 0, 1, 5, 'hDEAD, 1, 2, Byp ? 'hDEAD : 5, 6, Byp ? 2 : 3, 0, 3));
    vecs.push_back(mk(5, 1, 1, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0));
    vecs.push_back(mk(2, 6, 1, 0, 0, 0, 0, 0, 2, 6, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 'h55, 1, 0, Byp ? 'h55 : 0, Byp ? 'h55 : 0, 0, 0, 0));
    vecs.push_back(mk(0, 3, 1, 0, 0, 0, 0, 0, 'h55, 3, 1, 0, 1));

    @(negedge clk);
    @(negedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n        = vecs[i].rst;
      bus.rd_addr  = {vecs[i].a1, vecs[i].a0};
      bus.wr_en    = vecs[i].we;
      bus.wr_addr  = vecs[i].wa;
      bus.wr_data  = vecs[i].wd;
      bus.ld_issue = vecs[i].li;
      bus.ld_addr  = vecs[i].la;
      #1;
      check("rd_data0", i, 32'(bus.rd_data[15:0]), 32'(vecs[i].ed0));
      check("rd_data1", i, 32'(bus.rd_data[31:16]), 32'(vecs[i].ed1));
      check("rd_busy", i, 32'(bus.rd_busy), 32'(vecs[i].eb));
      check("ld_stall", i, 32'(bus.ld_stall), 32'(vecs[i].es));
      check("pend_cnt", i, 32'(bus.pend_cnt), 32'(vecs[i].ec));
    end

    // Fill every pending bit to reach pend_cnt = DEPTH, then drain by write-back.
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.ld_issue = 1'b1;
      bus.ld_addr  = 3'(i);
      #1;
      check("fill_cnt", i, 32'(bus.pend_cnt), i);
      check("fill_stall", i, 32'(bus.ld_stall), 0);
      @(negedge clk);
    end
    bus.ld_addr = 3'd3;
    #1;
    check("full_cnt", 0, 32'(bus.pend_cnt), 8);
    check("full_stall", 0, 32'(bus.ld_stall), 1);
    @(negedge clk);
    bus.ld_issue = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = 3'(i);
      bus.wr_data = 16'(100 + i);
      #1;
      check("drain_cnt", i, 32'(bus.pend_cnt), 8 - i);
      @(negedge clk);
    end
    bus.wr_en   = 1'b0;
    bus.rd_addr = {3'd7, 3'd6};
    #1;
    check("drain_done", 0, 32'(bus.pend_cnt), 0);
    check("drain_busy", 0, 32'(bus.rd_busy), 0);
    check("drain_r6", 0, 32'(bus.rd_data[15:0]), 106);
    check("drain_r7", 0, 32'(bus.rd_data[31:16]), 107);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file that succeeds the 8x16 two-read/one-write register file in the datapath. Each register has a pending-load scoreboard bit: the control unit sets it when a load is issued, and the RAM write-back clears it. Read ports report the busy state so the decoder can stall on operands that are not yet valid. Registers sit between instruction decode (operand reads) and RAM write-back (load writes).

## Interface
- DATA_W, 16, register width in bits
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers
- NUM_RD, 2, number of independent read ports (1..4)
- clk  input  1  clock; all state changes on rising edge
- rst_n  input  1  reset, synchronous, active-low
- rd_addr  input  NUM_RD*ADDR_W  read addresses; port p uses slice [p*ADDR_W +: ADDR_W]
- rd_data  output  NUM_RD*DATA_W  read data per port, combinational from rd_addr
- rd_busy  output  NUM_RD  port p addresses a register whose pending bit is set
- wr_en  input  1  write strobe (load write-back)
- wr_addr  input  ADDR_W  write address
- wr_data  input  DATA_W  write data
- ld_issue  input  1  a load to ld_addr has been issued; mark the register pending
- ld_addr  input  ADDR_W  target register of the issued load
- ld_stall  output  1  ld_issue && pending[ld_addr]: issue refused, combinational
- pend_cnt  output  ADDR_W+1  registered count of set pending bits

## Operation
- Storage: DEPTH x DATA_W flops. Pending: DEPTH bits.
- Reset (rst_n=0 at a rising edge):
  - register i loads i, zero-extended to DATA_W
  - all pending bits clear; pend_cnt=0
  - all other inputs ignored that cycle
- Write: wr_en=1 writes wr_data to wr_addr and clears pending[wr_addr]. A write to a non-pending register is legal and leaves pending unchanged.
- Load issue: ld_issue=1 with pending[ld_addr]=0 sets pending[ld_addr]. With pending[ld_addr]=1, ld_stall=1 and nothing changes.
- Same-cycle write and issue to the same address:
  - the data is written
  - pending ends set, because the new load wins
  - pend_cnt is unchanged net
  - ld_stall evaluates against the pre-edge pending bit
- Same-cycle write and issue to different addresses: both take effect.
- Read: rd_data[p] = reg[rd_addr[p]]. rd_busy[p] = pending[rd_addr[p]], pre-edge value. Multiple ports may read the same address.
- pend_cnt: popcount of pending, updated each edge as +1 on accepted issue, −1 on clear of a set bit, net otherwise. Range 0..DEPTH; cannot overflow, because issue to a pending register is refused.

## Timing
- Write latency 1: data is visible on rd_data the cycle after the wr_en edge (see BYPASS_EN).
- Issue latency 1: rd_busy rises the cycle after an accepted ld_issue.
- Outputs after reset:
  - rd_data = register contents at rd_addr (value i)
  - rd_busy=0
  - ld_stall=0
  - pend_cnt=0
- Reset asserted mid-operation discards all pending loads. A wr_en in that cycle is lost.
- No handshake on wr_en: every asserted cycle writes. ld_issue is a valid/ready pair with ready = !ld_stall.

## Configuration
- REGFILE_BYPASS_EN defined: write-through forwarding.
  - If wr_en && wr_addr==rd_addr[p], then rd_data[p]=wr_data and rd_busy[p]=0 in the same cycle.
  - The exception is a same-cycle ld_issue to that address, where rd_busy[p] follows the old pending bit.
- Not defined: reads return the pre-edge register value and pre-edge pending bit. Write-back is visible one cycle later.

## Structure
- Package regfile_pkg:
  - default DATA_W/ADDR_W/NUM_RD localparams
  - function popcount-free pend_cnt update helper
  - reset-value function init_val(i)
- One sub-module, regfile_scoreboard, holds the pending bits, ld_stall, pend_cnt and the set/clear priority. regfile_mp holds storage, read muxes and bypass.

## Test plan
- Reset, then read all 8 addresses over 4 cycles on 2 ports -> rd_data = 0..7, rd_busy=0, pend_cnt=0.
- ld_issue to r3; next cycle read r3 -> rd_busy[0]=1, pend_cnt=1. Then wr_en r3=75 -> next cycle rd_data=75, rd_busy=0, pend_cnt=0.
- ld_issue r4 twice in consecutive cycles -> second cycle ld_stall=1, pend_cnt stays 1.
- Same cycle: wr_en r4=175 and ld_issue r4 with r4 pending -> r4=175, pending set, pend_cnt=1.
- Under REGFILE_BYPASS_EN: wr_en r2=0x00AF with rd_addr[1]=2 -> rd_data[1]=0x00AF in the same cycle. Without the macro -> 2, then 0x00AF.
- Issue loads to r1, r5, r6; assert rst_n=0 for one cycle -> pend_cnt=0, all rd_busy=0, r5 reads 5.
